// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid exchange with imem and hands one instruction at a time to decode.
module if_fetch_ctrl #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSN_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INSN_W-1:0] if_insn,
    output logic              if_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              drop_q, drop_d;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] pc_d;
    logic [INSN_W-1:0] insn_d;
    logic              valid_d;
    logic [ADDR_W-1:0] br_tgt;
    logic              unused_br_lsb;

    // Redirect targets are word aligned; the low bits are ignored.
    assign br_tgt        = {br_addr[ADDR_W-1:2], 2'b00};
    assign unused_br_lsb = ^br_addr[1:0];

    // Next-state and next-output decision for every register.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        req_d      = imem_req;
        addr_d     = imem_addr;
        pc_d       = if_pc;
        insn_d     = if_insn;
        valid_d    = if_valid;

        if (!cpu_en) begin
            state_d    = S_IDLE;
            req_d      = 1'b0;
            valid_d    = 1'b0;
            fetch_pc_d = RESET_PC;
            unique case (1'b1)
                state_q == S_WAIT:              drop_d = !imem_rvalid;
                state_q == S_FETCH && imem_gnt: drop_d = 1'b1;
                state_q == S_IDLE && imem_rvalid: drop_d = 1'b0;
                default: ;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (drop_q && imem_rvalid) drop_d = 1'b0;
                    if (br_taken) fetch_pc_d = br_tgt;
                    if (!drop_q) begin
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_d;
                    end
                end
                S_FETCH: begin
                    if (br_taken) fetch_pc_d = br_tgt;
                    if (imem_gnt) begin
                        state_d = S_WAIT;
                        req_d   = 1'b0;
                        if (br_taken) drop_d = 1'b1;
                    end else begin
                        addr_d = fetch_pc_d;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (br_taken || drop_q) begin
                            if (br_taken) fetch_pc_d = br_tgt;
                            drop_d  = 1'b0;
                            state_d = S_FETCH;
                            req_d   = 1'b1;
                            addr_d  = fetch_pc_d;
                        end else begin
                            insn_d     = imem_rdata;
                            pc_d       = fetch_pc_q;
                            valid_d    = 1'b1;
                            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                            state_d    = S_HOLD;
                        end
                    end else if (br_taken) begin
                        fetch_pc_d = br_tgt;
                        drop_d     = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (br_taken || !stall) begin
                        if (br_taken) fetch_pc_d = br_tgt;
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_d;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; everything seen outside comes from here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            if_pc      <= '0;
            if_insn    <= '0;
            if_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            imem_req   <= req_d;
            imem_addr  <= addr_d;
            if_pc      <= pc_d;
            if_insn    <= insn_d;
            if_valid   <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus a randomized run checked
// against a program-order scoreboard and a bench-side memory model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        reset;
    logic        cpu_en;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;

    if_fetch_ctrl #(
        .ADDR_W  (32),
        .INSN_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_en     (cpu_en),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_insn    (if_insn),
        .if_valid   (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_en      = 1'b1;
        br_taken    = 1'b0;
        br_addr     = '0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Grant the pending request, wait lat extra cycles, return the word.
    task automatic serve(input int lat, output logic [31:0] ga);
        ga       = imem_addr;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        repeat (lat) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(ga);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_req: got %b want 0", imem_req);
        end
        checks++;
        if (imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC);
        end
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_insn !== 32'h0) begin
            failures++;
            $display("FAIL rst_if: got v=%b pc=%h insn=%h want 0/0/0",
                     if_valid, if_pc, if_insn);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL first_req: got req=%b addr=%h want 1/%h",
                     imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] e;
        for (int k = 0; k < 3; k++) begin
            e = 32'(k * 4);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== e) begin
                failures++;
                $display("FAIL seq_req: got req=%b addr=%h want 1/%h",
                         imem_req, imem_addr, e);
            end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL seq_wait: got req=%b v=%b want 0/0",
                         imem_req, if_valid);
            end
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(e);
            tick();
            imem_rvalid = 1'b0;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== e || if_insn !== mem_word(e)) begin
                failures++;
                $display("FAIL seq_deliver: got v=%b pc=%h insn=%h want 1/%h/%h",
                         if_valid, if_pc, if_insn, e, mem_word(e));
            end
            tick();
            checks++;
            if (if_valid !== 1'b0) begin
                failures++;
                $display("FAIL seq_consume: got v=%b want 0", if_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ga;
        do_reset();
        serve(0, ga);
        tick();
        serve(0, ga);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
            failures++;
            $display("FAIL stall_pre: got v=%b pc=%h want 1/4", if_valid, if_pc);
        end
        stall = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h4 ||
                if_insn !== mem_word(32'h4) || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold: got v=%b pc=%h insn=%h req=%b want 1/4/%h/0",
                         if_valid, if_pc, if_insn, imem_req, mem_word(32'h4));
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: got req=%b addr=%h v=%b want 1/8/0",
                     imem_req, imem_addr, if_valid);
        end
    endtask

    task automatic test_branch_wait();
        logic [31:0] ga;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        br_taken = 1'b1;
        br_addr  = 32'h103;
        tick();
        br_taken = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL brw_pending: got v=%b req=%b want 0/0", if_valid, imem_req);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h8);
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL brw_redirect: got v=%b req=%b addr=%h want 0/1/100",
                     if_valid, imem_req, imem_addr);
        end
        serve(1, ga);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_insn !== mem_word(32'h100)) begin
            failures++;
            $display("FAIL brw_target: got v=%b pc=%h insn=%h want 1/100/%h",
                     if_valid, if_pc, if_insn, mem_word(32'h100));
        end
        tick();
    endtask

    task automatic test_branch_fetch();
        logic [31:0] ga;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            failures++;
            $display("FAIL brf_pre: got req=%b addr=%h want 1/104", imem_req, imem_addr);
        end
        br_taken = 1'b1;
        br_addr  = 32'h40;
        tick();
        br_taken = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL brf_retarget: got req=%b addr=%h want 1/40", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL brf_hold: got req=%b addr=%h want 1/40", imem_req, imem_addr);
        end
        serve(2, ga);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_insn !== mem_word(32'h40)) begin
            failures++;
            $display("FAIL brf_target: got v=%b pc=%h insn=%h want 1/40/%h",
                     if_valid, if_pc, if_insn, mem_word(32'h40));
        end
        tick();
    endtask

    task automatic test_cpu_en_drop();
        logic [31:0] ga;
        do_reset();
        repeat (3) begin
            serve(0, ga);
            tick();
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            failures++;
            $display("FAIL en_pre: got req=%b addr=%h want 1/c", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        cpu_en = 1'b0;
        tick();
        cpu_en = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL en_blocked: got req=%b v=%b want 0/0", imem_req, if_valid);
            end
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'hC);
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL en_discard: got req=%b v=%b want 0/0", imem_req, if_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL en_restart: got req=%b addr=%h v=%b want 1/%h/0",
                     imem_req, imem_addr, if_valid, RST_PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ga;
        br_taken = 1'b1;
        br_addr  = 32'hFFFF_FFFE;
        tick();
        br_taken = 1'b0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_target: got addr=%h want fffffffc", imem_addr);
        end
        serve(0, ga);
        checks++;
        if (if_pc !== 32'hFFFF_FFFC || if_insn !== mem_word(32'hFFFF_FFFC)) begin
            failures++;
            $display("FAIL wrap_last: got pc=%h insn=%h want fffffffc/%h",
                     if_pc, if_insn, mem_word(32'hFFFF_FFFC));
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        serve(0, ga);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_insn !== mem_word(32'h0)) begin
            failures++;
            $display("FAIL wrap_fetch0: got v=%b pc=%h insn=%h want 1/0/%h",
                     if_valid, if_pc, if_insn, mem_word(32'h0));
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [31:0] ga;
        serve(0, ga);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_insn !== 32'h0) begin
            failures++;
            $display("FAIL arst_hold: got v=%b pc=%h insn=%h want 0/0/0",
                     if_valid, if_pc, if_insn);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL arst_refetch: got req=%b want 1", imem_req);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL arst_fetch: got req=%b addr=%h want 0/%h",
                     imem_req, imem_addr, RST_PC);
        end
        cpu_en = 1'b0;
        tick();
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        tick();
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL arst_late: got v=%b req=%b want 0/0", if_valid, imem_req);
        end
        cpu_en = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL arst_resume: got req=%b addr=%h want 1/%h",
                     imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        logic [31:0] cur_addr;
        logic [31:0] v_pc;
        logic [31:0] v_insn;
        logic        pend;
        logic        cur_req;
        logic        v_valid;
        int          lat;
        int          delivered;
        do_reset();
        exp_pc    = RST_PC;
        pend      = 1'b0;
        pend_addr = '0;
        lat       = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            cur_req  = imem_req;
            cur_addr = imem_addr;
            v_valid  = if_valid;
            v_pc     = if_pc;
            v_insn   = if_insn;
            checks++;
            if (imem_req && pend) begin
                failures++;
                $display("FAIL rnd_overlap: got req=1 while outstanding, cycle %0d", cyc);
            end
            cpu_en   = ($urandom_range(0, 49) != 0);
            br_taken = ($urandom_range(0, 11) == 0);
            br_addr  = $urandom;
            stall    = ($urandom_range(0, 2) == 0);
            imem_gnt = ($urandom_range(0, 2) != 0);
            if (pend && lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            tick();
            if (imem_rvalid) pend = 1'b0;
            else if (pend) lat--;
            if (cur_req && imem_gnt) begin
                pend      = 1'b1;
                pend_addr = cur_addr;
                lat       = $urandom_range(0, 2);
            end
            if (v_valid) begin
                checks++;
                if (stall && !br_taken && cpu_en) begin
                    if (if_valid !== 1'b1 || if_pc !== v_pc || if_insn !== v_insn) begin
                        failures++;
                        $display("FAIL rnd_stall: got v=%b pc=%h insn=%h want 1/%h/%h",
                                 if_valid, if_pc, if_insn, v_pc, v_insn);
                    end
                end else if (if_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_release: got v=%b want 0, cycle %0d", if_valid, cyc);
                end
            end else if (if_valid) begin
                checks++;
                if (!cpu_en || br_taken) begin
                    failures++;
                    $display("FAIL rnd_redirect_deliver: got v=1 pc=%h want v=0", if_pc);
                end
                checks++;
                if (if_pc !== exp_pc || if_insn !== mem_word(exp_pc)) begin
                    failures++;
                    $display("FAIL rnd_order: got pc=%h insn=%h want %h/%h",
                             if_pc, if_insn, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (!cpu_en) exp_pc = RST_PC;
            else if (br_taken) exp_pc = {br_addr[31:2], 2'b00};
        end
        idle_inputs();
        checks++;
        if (delivered < 100) begin
            failures++;
            $display("FAIL rnd_progress: got %0d deliveries want >= 100", delivered);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_seq_fetch();
        test_stall();
        test_branch_wait();
        test_branch_fetch();
        test_cpu_en_drop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
